// File: rtl/fetch_unit.sv
// Instruction-fetch stage: captures the IP, runs the req/ack exchange with
// instruction memory and hands the registered word to decode under valid/ready.
module fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_WORD       = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] IP,
    output logic        IP_TAKE,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    input  logic        FLUSH,
    output logic [31:0] INSTR,
    output logic [31:0] INSTR_PC,
    output logic [6:0]  OP,
    output logic        INSTR_VALID,
    input  logic        DEC_READY,
    output logic        FETCH_ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DROP,
        S_HOLD,
        S_ERR
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ip_take_q, ip_take_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_err_q, fetch_err_d;

    logic ip_aligned;
    logic timeout_hit;
    logic capture;
    logic waiting;

    assign ip_aligned  = (IP[1:0] == 2'b00);
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);
    assign waiting     = (state_q == S_REQ) || (state_q == S_DROP);
    // A new IP is considered in IDLE every cycle, and in HOLD only when decode takes the word.
    assign capture     = (state_q == S_IDLE) ||
                         ((state_q == S_HOLD) && DEC_READY && !FLUSH);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ip_take_q     <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            instr_q       <= NOP_WORD;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ip_take_q     <= ip_take_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = ip_aligned ? S_REQ : S_ERR;
            S_REQ: begin
                if (IMEM_ACK)         state_d = FLUSH ? S_IDLE : S_HOLD;
                else if (FLUSH)       state_d = S_DROP;
                else if (timeout_hit) state_d = S_ERR;
            end
            // The bus transaction must complete; further flushes change nothing.
            S_DROP: begin
                if (IMEM_ACK)         state_d = S_IDLE;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_HOLD: begin
                if (FLUSH)            state_d = S_IDLE;
                else if (DEC_READY)   state_d = ip_aligned ? S_REQ : S_ERR;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ip_take_d     = capture && ip_aligned;
        imem_req_d    = (state_d == S_REQ) || (state_d == S_DROP);
        imem_addr_d   = imem_addr_q;
        cnt_d         = cnt_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q || (state_d == S_ERR);

        if (capture && ip_aligned) begin
            imem_addr_d = IP;
            cnt_d       = '0;
        end else if (waiting && !IMEM_ACK) begin
            cnt_d = cnt_q + 8'd1;
        end

        if ((state_q == S_REQ) && IMEM_ACK && !FLUSH) begin
            instr_d       = IMEM_RDATA;
            instr_pc_d    = imem_addr_q;
            instr_valid_d = 1'b1;
        end else if ((state_q == S_HOLD) && (FLUSH || DEC_READY)) begin
            instr_d       = NOP_WORD;
            instr_valid_d = 1'b0;
        end
    end

    assign IP_TAKE     = ip_take_q;
    assign IMEM_REQ    = imem_req_q;
    assign IMEM_ADDR   = imem_addr_q;
    assign INSTR       = instr_q;
    assign INSTR_PC    = instr_pc_q;
    assign OP          = instr_q[6:0];
    assign INSTR_VALID = instr_valid_q;
    assign FETCH_ERR   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each task drives one scenario and checks
// the registered outputs against hand-computed values.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] IP;
    logic        IP_TAKE;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic        FLUSH;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic [6:0]  OP;
    logic        INSTR_VALID;
    logic        DEC_READY;
    logic        FETCH_ERR;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    fetch_unit #(
        .TIMEOUT_CYCLES(4),
        .NOP_WORD(NOP)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .IP(IP),
        .IP_TAKE(IP_TAKE),
        .IMEM_REQ(IMEM_REQ),
        .IMEM_ADDR(IMEM_ADDR),
        .IMEM_ACK(IMEM_ACK),
        .IMEM_RDATA(IMEM_RDATA),
        .FLUSH(FLUSH),
        .INSTR(INSTR),
        .INSTR_PC(INSTR_PC),
        .OP(OP),
        .INSTR_VALID(INSTR_VALID),
        .DEC_READY(DEC_READY),
        .FETCH_ERR(FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] ip_val);
        RESET_N    = 1'b0;
        IP         = ip_val;
        IMEM_ACK   = 1'b0;
        IMEM_RDATA = 32'h0;
        FLUSH      = 1'b0;
        DEC_READY  = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(32'h0);
        RESET_N = 1'b0;
        #1;
        total++;
        if ({IP_TAKE, IMEM_REQ, INSTR_VALID, FETCH_ERR} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b want 0000", {IP_TAKE, IMEM_REQ, INSTR_VALID, FETCH_ERR});
        end
        total++;
        if ({IMEM_ADDR, INSTR, INSTR_PC, OP} !== {32'h0, NOP, 32'h0, 7'h13}) begin
            bad++;
            $display("[TB] FAIL reset_data: addr=%h instr=%h pc=%h op=%h want 0/00000013/0/13", IMEM_ADDR, INSTR, INSTR_PC, OP);
        end
    endtask

    task automatic test_basic();
        do_reset(32'h0);
        tick();
        total++;
        if ({IP_TAKE, IMEM_REQ, INSTR_VALID, IMEM_ADDR} !== {3'b110, 32'h0}) begin
            bad++;
            $display("[TB] FAIL basic_capture: take=%b req=%b valid=%b addr=%h want 1 1 0 0", IP_TAKE, IMEM_REQ, INSTR_VALID, IMEM_ADDR);
        end
        IP = 32'h4;
        IMEM_ACK = 1'b1;
        IMEM_RDATA = 32'h00500093;
        tick();
        IMEM_ACK = 1'b0;
        total++;
        if ({IP_TAKE, IMEM_REQ, INSTR_VALID} !== 3'b001 || INSTR !== 32'h00500093 || OP !== 7'h13 || INSTR_PC !== 32'h0) begin
            bad++;
            $display("[TB] FAIL basic_hold: take=%b req=%b valid=%b instr=%h op=%h pc=%h want 0 0 1 00500093 13 0", IP_TAKE, IMEM_REQ, INSTR_VALID, INSTR, OP, INSTR_PC);
        end
        DEC_READY = 1'b1;
        tick();
        DEC_READY = 1'b0;
        total++;
        if ({IP_TAKE, IMEM_REQ, INSTR_VALID} !== 3'b110 || INSTR !== NOP || IMEM_ADDR !== 32'h4) begin
            bad++;
            $display("[TB] FAIL basic_accept: take=%b req=%b valid=%b instr=%h addr=%h want 1 1 0 00000013 4", IP_TAKE, IMEM_REQ, INSTR_VALID, INSTR, IMEM_ADDR);
        end
    endtask

    task automatic test_backpressure();
        do_reset(32'h20);
        tick();
        IP = 32'h24;
        IMEM_ACK = 1'b1;
        IMEM_RDATA = 32'h0000006F;
        tick();
        IMEM_ACK = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({INSTR_VALID, IP_TAKE, IMEM_REQ, OP, INSTR, INSTR_PC} !== {3'b100, 7'h6F, 32'h0000006F, 32'h20}) begin
                bad++;
                $display("[TB] FAIL stall_%0d: valid=%b take=%b req=%b op=%h instr=%h pc=%h want 1 0 0 6f 0000006f 20", i, INSTR_VALID, IP_TAKE, IMEM_REQ, OP, INSTR, INSTR_PC);
            end
        end
        DEC_READY = 1'b1;
        tick();
        DEC_READY = 1'b0;
        total++;
        if ({IP_TAKE, IMEM_REQ, INSTR_VALID} !== 3'b110 || IMEM_ADDR !== 32'h24) begin
            bad++;
            $display("[TB] FAIL stall_release: take=%b req=%b valid=%b addr=%h want 1 1 0 24", IP_TAKE, IMEM_REQ, INSTR_VALID, IMEM_ADDR);
        end
    endtask

    task automatic test_flush_wait();
        do_reset(32'h10);
        tick();
        tick();
        total++;
        if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, 32'h10}) begin
            bad++;
            $display("[TB] FAIL fw_wait1: req=%b addr=%h want 1 10", IMEM_REQ, IMEM_ADDR);
        end
        FLUSH = 1'b1;
        IP = 32'h40;
        tick();
        FLUSH = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({IMEM_REQ, INSTR_VALID, IMEM_ADDR, INSTR} !== {2'b10, 32'h10, NOP}) begin
                bad++;
                $display("[TB] FAIL fw_drop_%0d: req=%b valid=%b addr=%h instr=%h want 1 0 10 00000013", i, IMEM_REQ, INSTR_VALID, IMEM_ADDR, INSTR);
            end
            if (i == 0) begin
                FLUSH = 1'b1;
                tick();
                FLUSH = 1'b0;
            end
        end
        IMEM_ACK = 1'b1;
        IMEM_RDATA = 32'hDEADBEEF;
        tick();
        IMEM_ACK = 1'b0;
        total++;
        if ({IMEM_REQ, INSTR_VALID, FETCH_ERR, IP_TAKE, INSTR} !== {4'b0000, NOP}) begin
            bad++;
            $display("[TB] FAIL fw_ack_drop: req=%b valid=%b err=%b take=%b instr=%h want 0 0 0 0 00000013", IMEM_REQ, INSTR_VALID, FETCH_ERR, IP_TAKE, INSTR);
        end
        tick();
        total++;
        if ({IP_TAKE, IMEM_REQ, IMEM_ADDR} !== {2'b11, 32'h40}) begin
            bad++;
            $display("[TB] FAIL fw_recapture: take=%b req=%b addr=%h want 1 1 40", IP_TAKE, IMEM_REQ, IMEM_ADDR);
        end
    endtask

    task automatic test_flush_hold();
        do_reset(32'h30);
        tick();
        IMEM_ACK = 1'b1;
        IMEM_RDATA = 32'h00A00113;
        IP = 32'h34;
        tick();
        IMEM_ACK = 1'b0;
        total++;
        if ({INSTR_VALID, INSTR, INSTR_PC} !== {1'b1, 32'h00A00113, 32'h30}) begin
            bad++;
            $display("[TB] FAIL fh_hold: valid=%b instr=%h pc=%h want 1 00a00113 30", INSTR_VALID, INSTR, INSTR_PC);
        end
        FLUSH = 1'b1;
        DEC_READY = 1'b1;
        tick();
        FLUSH = 1'b0;
        DEC_READY = 1'b0;
        total++;
        if ({INSTR_VALID, IP_TAKE, IMEM_REQ, INSTR} !== {3'b000, NOP}) begin
            bad++;
            $display("[TB] FAIL fh_flush: valid=%b take=%b req=%b instr=%h want 0 0 0 00000013", INSTR_VALID, IP_TAKE, IMEM_REQ, INSTR);
        end
        IP = 32'h80;
        tick();
        total++;
        if ({IP_TAKE, IMEM_REQ, IMEM_ADDR} !== {2'b11, 32'h80}) begin
            bad++;
            $display("[TB] FAIL fh_recapture: take=%b req=%b addr=%h want 1 1 80", IP_TAKE, IMEM_REQ, IMEM_ADDR);
        end
    endtask

    task automatic test_timeout();
        do_reset(32'h50);
        tick();
        for (int i = 0; i < 3; i++) tick();
        total++;
        if ({IMEM_REQ, FETCH_ERR} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL to_cycle4: req=%b err=%b want 1 0", IMEM_REQ, FETCH_ERR);
        end
        tick();
        total++;
        if ({IMEM_REQ, FETCH_ERR} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL to_expire: req=%b err=%b want 0 1", IMEM_REQ, FETCH_ERR);
        end
        IMEM_ACK = 1'b1;
        IMEM_RDATA = 32'h12345678;
        IP = 32'h60;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({IMEM_REQ, FETCH_ERR, IP_TAKE, INSTR_VALID, INSTR} !== {4'b0100, NOP}) begin
                bad++;
                $display("[TB] FAIL to_sticky_%0d: req=%b err=%b take=%b valid=%b instr=%h want 0 1 0 0 00000013", i, IMEM_REQ, FETCH_ERR, IP_TAKE, INSTR_VALID, INSTR);
            end
        end
        IMEM_ACK = 1'b0;
        do_reset(32'h60);
        tick();
        total++;
        if ({FETCH_ERR, IP_TAKE, IMEM_REQ, IMEM_ADDR} !== {3'b011, 32'h60}) begin
            bad++;
            $display("[TB] FAIL to_recover: err=%b take=%b req=%b addr=%h want 0 1 1 60", FETCH_ERR, IP_TAKE, IMEM_REQ, IMEM_ADDR);
        end
    endtask

    task automatic test_misaligned();
        do_reset(32'h102);
        tick();
        total++;
        if ({FETCH_ERR, IMEM_REQ, IP_TAKE} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL mis_err: err=%b req=%b take=%b want 1 0 0", FETCH_ERR, IMEM_REQ, IP_TAKE);
        end
        IP = 32'h104;
        tick();
        tick();
        total++;
        if ({FETCH_ERR, IMEM_REQ, IP_TAKE} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL mis_sticky: err=%b req=%b take=%b want 1 0 0", FETCH_ERR, IMEM_REQ, IP_TAKE);
        end
    endtask

    task automatic test_async_reset();
        do_reset(32'h70);
        tick();
        total++;
        if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, 32'h70}) begin
            bad++;
            $display("[TB] FAIL ar_req: req=%b addr=%h want 1 70", IMEM_REQ, IMEM_ADDR);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        total++;
        if ({IP_TAKE, IMEM_REQ, INSTR_VALID, FETCH_ERR, IMEM_ADDR, INSTR, INSTR_PC} !== {4'b0000, 32'h0, NOP, 32'h0}) begin
            bad++;
            $display("[TB] FAIL ar_async: take=%b req=%b valid=%b err=%b addr=%h instr=%h pc=%h want 0 0 0 0 0 00000013 0", IP_TAKE, IMEM_REQ, INSTR_VALID, FETCH_ERR, IMEM_ADDR, INSTR, INSTR_PC);
        end
        tick();
        IP = 32'h74;
        IMEM_ACK = 1'b1;
        IMEM_RDATA = 32'hFFFFFFFF;
        RESET_N = 1'b1;
        tick();
        IMEM_ACK = 1'b0;
        total++;
        if ({INSTR_VALID, IP_TAKE, IMEM_REQ, IMEM_ADDR, INSTR} !== {3'b011, 32'h74, NOP}) begin
            bad++;
            $display("[TB] FAIL ar_late_ack: valid=%b take=%b req=%b addr=%h instr=%h want 0 1 1 74 00000013", INSTR_VALID, IP_TAKE, IMEM_REQ, IMEM_ADDR, INSTR);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush_wait();
        test_flush_hold();
        test_timeout();
        test_misaligned();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
